sc_debug_stepper: RTL and testbench

//  Run/step/breakpoint controller with an instruction trace buffer for the single-cycle processor.

---
 rtl/sc_debug_pkg.sv | 25 ++
 rtl/sc_trace_fifo.sv | 81 ++++++++
 rtl/sc_debug_stepper.sv | 172 +++++++++++++++++
 tb/tb_sc_debug_stepper.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_debug_pkg.sv
// Shared definitions for the single-cycle core debug stepper.
//   - cmd_op_e    : host command encodings carried on cmd_op
//   - dbg_state_e : stepper FSM state encodings (also visible on dbgState)
//   - Trace entries are packed as {pc, inst, data}, so pc sits in the MSBs.
//   - idxWidth()  : index width that stays at least one bit wide for single-entry tables
package sc_debug_pkg;

    typedef enum logic [1:0] {
        CMD_HALT  = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } dbg_state_e;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sc_trace_fifo.sv
// Instruction trace FIFO with optional overwrite-oldest behaviour.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   push, wrData write one entry
//   pop          remove the head entry (ignored when empty)
//   clear        empty the FIFO and clear overflow; wins over push/pop
//   rdData       head entry, valid when valid=1
//   full, count  occupancy status
//   overflow     sticky: an entry was dropped to make room (OVERWRITE=1 only)
module sc_trace_fifo #(
    parameter int WIDTH     = 96,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wrData,
    output logic [WIDTH-1:0]       rdData,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW:0]      cntQ;
    logic             ovfQ;

    logic popEff;
    logic pushEff;
    logic dropOld;
    logic rdAdvance;

    always_comb begin
        popEff    = pop && (cntQ != '0);
        // A full FIFO still accepts a push when the head leaves this cycle,
        // or when it may sacrifice the oldest entry.
        pushEff   = push && ((cntQ != FULL_CNT) || popEff || OVERWRITE);
        dropOld   = push && (cntQ == FULL_CNT) && !popEff && OVERWRITE;
        rdAdvance = popEff || dropOld;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cntQ  <= '0;
            ovfQ  <= 1'b0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cntQ  <= '0;
            ovfQ  <= 1'b0;
        end else begin
            if (pushEff)   wrPtr <= wrPtr + 1'b1;
            if (rdAdvance) rdPtr <= rdPtr + 1'b1;
            if (pushEff && !rdAdvance)      cntQ <= cntQ + 1'b1;
            else if (!pushEff && rdAdvance) cntQ <= cntQ - 1'b1;
            if (dropOld) ovfQ <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pushEff && !clear) mem[wrPtr] <= wrData;
    end

    assign rdData   = mem[rdPtr];
    assign valid    = (cntQ != '0);
    assign full     = (cntQ == FULL_CNT);
    assign count    = cntQ;
    assign overflow = ovfQ;

endmodule

// File: rtl/sc_debug_stepper.sv
// Run/step/breakpoint controller with instruction trace for the single-cycle core.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cmd_valid/cmd_op/cmd_arg   host command (always accepted), effective next cycle
//   bp_wr/bp_idx/bp_addr/bp_en breakpoint slot write, effective next cycle
//   pc/inst_word/wb_data       current core PC, instruction and writeback value
//   core_en                    core retires the current instruction this cycle
//   halted                     FSM is in HALT
//   bp_hit/bp_hit_idx          one-cycle pulse after a breakpoint stop / lowest matching slot
//   trc_*                      trace FIFO head (valid/ready pop), occupancy, sticky overflow
//   dbgState                   raw FSM state (dbg_state_e)
// Handshake: the trace head is consumed on any cycle where trc_valid && trc_ready;
// trc_pc/trc_inst/trc_data are stable while trc_valid=1 and no pop occurs.
module sc_debug_stepper
    import sc_debug_pkg::*;
#(
    parameter int DBITS        = 32,
    parameter int INST_BITS    = 32,
    parameter int NUM_BP       = 4,
    parameter int TRACE_DEPTH  = 16,
    parameter int STEP_BITS    = 8,
    parameter bit STOP_ON_FULL = 1'b1,
    parameter bit RESET_RUN    = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    input  logic [1:0]                     cmd_op,
    input  logic [STEP_BITS-1:0]           cmd_arg,
    input  logic                           bp_wr,
    input  logic [idxWidth(NUM_BP)-1:0]    bp_idx,
    input  logic [DBITS-1:0]               bp_addr,
    input  logic                           bp_en,
    input  logic [DBITS-1:0]               pc,
    input  logic [INST_BITS-1:0]           inst_word,
    input  logic [DBITS-1:0]               wb_data,
    output logic                           core_en,
    output logic                           halted,
    output logic                           bp_hit,
    output logic [idxWidth(NUM_BP)-1:0]    bp_hit_idx,
    output logic                           trc_valid,
    input  logic                           trc_ready,
    output logic [DBITS-1:0]               trc_pc,
    output logic [INST_BITS-1:0]           trc_inst,
    output logic [DBITS-1:0]               trc_data,
    output logic [$clog2(TRACE_DEPTH):0]   trc_count,
    output logic                           trc_overflow,
    output logic [1:0]                     dbgState
);

    localparam int BP_IDX_W = idxWidth(NUM_BP);
    localparam int TRC_W    = 2 * DBITS + INST_BITS;

    dbg_state_e           stateQ, stateD;
    logic [STEP_BITS-1:0] cntQ, cntD;
    logic                 skipQ, skipD;

    logic [DBITS-3:0]     bpAddrQ [NUM_BP];
    logic [NUM_BP-1:0]    bpEnQ;
    logic                 bpAny;
    logic [BP_IDX_W-1:0]  bpFirst;

    logic                 active, bpStop, stall, retire, coreEn;
    logic                 fifoFull, fifoPop, fifoClear;
    logic [TRC_W-1:0]     trcHead;

    // Breakpoints compare word addresses only; the byte offset is dropped.
    logic unusedBpLow;
    assign unusedBpLow = ^bp_addr[1:0];

    // Lowest-numbered enabled slot wins: scan downward so the last assignment is the lowest hit.
    always_comb begin
        bpAny   = 1'b0;
        bpFirst = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bpEnQ[i] && (bpAddrQ[i] == pc[DBITS-1:2])) begin
                bpAny   = 1'b1;
                bpFirst = BP_IDX_W'(i);
            end
        end
    end

    always_comb begin
        active    = (stateQ != ST_HALT);
        fifoPop   = trc_valid && trc_ready;
        fifoClear = cmd_valid && (cmd_op == CMD_CLEAR);
        bpStop    = active && !skipQ && bpAny;
        stall     = STOP_ON_FULL && fifoFull && !fifoPop;
        retire    = active && !bpStop && !stall;
        // Gated by reset so the core is held while reset is asserted, even in RUN.
        coreEn    = retire && reset;
    end

    // Next-state: retirement/breakpoint effects first, then an accepted command overrides.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        skipD  = skipQ;
        if (retire) begin
            skipD = 1'b0;
            if (stateQ == ST_STEP) begin
                cntD = cntQ - 1'b1;
                if (cntQ <= STEP_BITS'(1)) stateD = ST_HALT;
            end
        end
        if (bpStop) stateD = ST_HALT;
        if (cmd_valid) begin
            case (cmd_op)
                CMD_HALT: stateD = ST_HALT;
                CMD_RUN: begin
                    stateD = ST_RUN;
                    skipD  = 1'b1;
                end
                CMD_STEP: begin
                    stateD = ST_STEP;
                    cntD   = (cmd_arg == '0) ? STEP_BITS'(1) : cmd_arg;
                    skipD  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ     <= RESET_RUN ? ST_RUN : ST_HALT;
            cntQ       <= '0;
            skipQ      <= 1'b0;
            bp_hit     <= 1'b0;
            bp_hit_idx <= '0;
            bpEnQ      <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            skipQ  <= skipD;
            bp_hit <= bpStop;
            if (bpStop) bp_hit_idx <= bpFirst;
            if (bp_wr && (int'(bp_idx) < NUM_BP)) bpEnQ[bp_idx] <= bp_en;
        end
    end

    // Addresses need no reset: a slot is ignored until its enable is written.
    always_ff @(posedge clk) begin
        if (bp_wr && (int'(bp_idx) < NUM_BP)) bpAddrQ[bp_idx] <= bp_addr[DBITS-1:2];
    end

    sc_trace_fifo #(
        .WIDTH    (TRC_W),
        .DEPTH    (TRACE_DEPTH),
        .OVERWRITE(!STOP_ON_FULL)
    ) u_trace (
        .clk     (clk),
        .reset   (reset),
        .push    (coreEn),
        .pop     (fifoPop),
        .clear   (fifoClear),
        .wrData  ({pc, inst_word, wb_data}),
        .rdData  (trcHead),
        .valid   (trc_valid),
        .full    (fifoFull),
        .count   (trc_count),
        .overflow(trc_overflow)
    );

    assign trc_pc   = trcHead[TRC_W-1 -: DBITS];
    assign trc_inst = trcHead[DBITS+INST_BITS-1 -: INST_BITS];
    assign trc_data = trcHead[DBITS-1:0];
    assign core_en  = coreEn;
    assign halted   = (stateQ == ST_HALT);
    assign dbgState = stateQ;

endmodule

// File: tb/tb_sc_debug_stepper.sv
module tb_sc_debug_stepper;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        cmdValid, bpWr, bpEn, trcReady;
    logic [1:0]  cmdOp, bpIdx;
    logic [7:0]  cmdArg;
    logic [31:0] bpAddr, pc, instWord, wbData;

    // dut A: STOP_ON_FULL=1, dut B: STOP_ON_FULL=0, both depth 4
    logic        coreEnA, haltedA, bpHitA, validA, ovfA;
    logic [1:0]  hitIdxA, stA;
    logic [31:0] tPcA, tInstA, tDataA;
    logic [2:0]  countA;
    logic        coreEnB, haltedB, bpHitB, validB, ovfB;
    logic [1:0]  hitIdxB, stB;
    logic [31:0] tPcB, tInstB, tDataB;
    logic [2:0]  countB;

    sc_debug_stepper #(.TRACE_DEPTH(4), .STOP_ON_FULL(1'b1), .RESET_RUN(1'b1)) dutA (
        .clk(clk), .reset(reset), .cmd_valid(cmdValid), .cmd_op(cmdOp), .cmd_arg(cmdArg),
        .bp_wr(bpWr), .bp_idx(bpIdx), .bp_addr(bpAddr), .bp_en(bpEn),
        .pc(pc), .inst_word(instWord), .wb_data(wbData),
        .core_en(coreEnA), .halted(haltedA), .bp_hit(bpHitA), .bp_hit_idx(hitIdxA),
        .trc_valid(validA), .trc_ready(trcReady), .trc_pc(tPcA), .trc_inst(tInstA),
        .trc_data(tDataA), .trc_count(countA), .trc_overflow(ovfA), .dbgState(stA)
    );

    sc_debug_stepper #(.TRACE_DEPTH(4), .STOP_ON_FULL(1'b0), .RESET_RUN(1'b1)) dutB (
        .clk(clk), .reset(reset), .cmd_valid(cmdValid), .cmd_op(cmdOp), .cmd_arg(cmdArg),
        .bp_wr(bpWr), .bp_idx(bpIdx), .bp_addr(bpAddr), .bp_en(bpEn),
        .pc(pc), .inst_word(instWord), .wb_data(wbData),
        .core_en(coreEnB), .halted(haltedB), .bp_hit(bpHitB), .bp_hit_idx(hitIdxB),
        .trc_valid(validB), .trc_ready(trcReady), .trc_pc(tPcB), .trc_inst(tInstB),
        .trc_data(tDataB), .trc_count(countB), .trc_overflow(ovfB), .dbgState(stB)
    );

    // ---------------- scoreboard ----------------
    int nChecks = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instOf(input logic [31:0] p);
        return {16'hC0DE, p[15:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic cv, input logic [1:0] op, input logic [7:0] arg,
                         input logic [31:0] p, input logic rdy);
        cmdValid = cv;  cmdOp = op;  cmdArg = arg;
        pc = p;  instWord = instOf(p);  wbData = ~p;
        trcReady = rdy;
        bpWr = 1'b0;  bpIdx = '0;  bpAddr = '0;  bpEn = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        cv;
        logic [1:0]  op;
        logic [7:0]  arg;
        logic [31:0] pc;
        logic        rdy;
        logic        bw;
        logic [1:0]  bi;
        logic [31:0] ba;
        logic        be;
        logic        eCore;
        logic        eHalt;
        logic        eHit;
        logic [2:0]  eCnt;
        logic        chkHead;
        logic [31:0] eHead;
        logic        chkIdx;
        logic [1:0]  eIdx;
    } vec_t;

    vec_t vecs[$];

    task automatic addV(input logic cv, input logic [1:0] op, input logic [7:0] arg,
                        input logic [31:0] p, input logic rdy,
                        input logic eCore, input logic eHalt, input logic eHit,
                        input logic [2:0] eCnt);
        vec_t v;
        v = '{default: '0};
        v.cv = cv;  v.op = op;  v.arg = arg;  v.pc = p;  v.rdy = rdy;
        v.eCore = eCore;  v.eHalt = eHalt;  v.eHit = eHit;  v.eCnt = eCnt;
        vecs.push_back(v);
    endtask

    task automatic withBp(input logic [1:0] idx, input logic [31:0] addr, input logic en);
        vecs[vecs.size()-1].bw = 1'b1;
        vecs[vecs.size()-1].bi = idx;
        vecs[vecs.size()-1].ba = addr;
        vecs[vecs.size()-1].be = en;
    endtask

    task automatic withHead(input logic [31:0] p);
        vecs[vecs.size()-1].chkHead = 1'b1;
        vecs[vecs.size()-1].eHead = p;
    endtask

    task automatic withIdx(input logic [1:0] idx);
        vecs[vecs.size()-1].chkIdx = 1'b1;
        vecs[vecs.size()-1].eIdx = idx;
    endtask

    task automatic buildTable();
        // free run from reset, 3 retirements, then HALT and drain
        addV(0, OP_HALT, 0, 32'h40, 0, 1, 0, 0, 0);
        addV(0, OP_HALT, 0, 32'h44, 0, 1, 0, 0, 1);
        addV(1, OP_HALT, 0, 32'h48, 0, 1, 0, 0, 2);
        addV(0, OP_HALT, 0, 32'h4C, 1, 0, 1, 0, 3);  withHead(32'h40);
        addV(0, OP_HALT, 0, 32'h4C, 1, 0, 1, 0, 2);  withHead(32'h44);
        addV(0, OP_HALT, 0, 32'h4C, 1, 0, 1, 0, 1);  withHead(32'h48);
        addV(0, OP_HALT, 0, 32'h4C, 0, 0, 1, 0, 0);
        // STEP 2, then STEP 0 (one retirement), then clear
        addV(1, OP_STEP, 2, 32'h100, 0, 0, 1, 0, 0);
        addV(0, OP_HALT, 0, 32'h100, 0, 1, 0, 0, 0);
        addV(0, OP_HALT, 0, 32'h104, 0, 1, 0, 0, 1);
        addV(0, OP_HALT, 0, 32'h108, 0, 0, 1, 0, 2);
        addV(1, OP_STEP, 0, 32'h108, 0, 0, 1, 0, 2);
        addV(0, OP_HALT, 0, 32'h108, 0, 1, 0, 0, 2);
        addV(0, OP_HALT, 0, 32'h10C, 0, 0, 1, 0, 3);
        addV(1, OP_CLR,  0, 32'h10C, 0, 0, 1, 0, 3);
        addV(0, OP_HALT, 0, 32'h10C, 0, 0, 1, 0, 0);
        // breakpoints: slot2 (byte offset ignored), slot3 same word, slot0 disabled
        addV(0, OP_HALT, 0, 32'h10C, 0, 0, 1, 0, 0);  withBp(2, 32'h5A, 1);
        addV(0, OP_HALT, 0, 32'h10C, 0, 0, 1, 0, 0);  withBp(3, 32'h58, 1);
        addV(0, OP_HALT, 0, 32'h10C, 0, 0, 1, 0, 0);  withBp(0, 32'h54, 0);
        addV(1, OP_RUN,  0, 32'h50, 0, 0, 1, 0, 0);
        addV(0, OP_HALT, 0, 32'h50, 0, 1, 0, 0, 0);
        addV(0, OP_HALT, 0, 32'h54, 0, 1, 0, 0, 1);
        addV(0, OP_HALT, 0, 32'h58, 0, 0, 0, 0, 2);
        addV(0, OP_HALT, 0, 32'h58, 0, 0, 1, 1, 2);  withIdx(2);
        addV(0, OP_HALT, 0, 32'h58, 0, 0, 1, 0, 2);  withIdx(2);
        addV(1, OP_RUN,  0, 32'h58, 0, 0, 1, 0, 2);
        addV(0, OP_HALT, 0, 32'h58, 0, 1, 0, 0, 2);
        addV(1, OP_HALT, 0, 32'h5C, 0, 1, 0, 0, 3);
        addV(0, OP_HALT, 0, 32'h60, 0, 0, 1, 0, 4);
        addV(1, OP_CLR,  0, 32'h60, 0, 0, 1, 0, 4);
        addV(0, OP_HALT, 0, 32'h60, 0, 0, 1, 0, 0);  withIdx(2);
        // stop-on-full: 4 retirements, stall, a pop lets exactly one more through
        addV(1, OP_RUN,  0, 32'h200, 0, 0, 1, 0, 0);
        addV(0, OP_HALT, 0, 32'h200, 0, 1, 0, 0, 0);
        addV(0, OP_HALT, 0, 32'h204, 0, 1, 0, 0, 1);
        addV(0, OP_HALT, 0, 32'h208, 0, 1, 0, 0, 2);
        addV(0, OP_HALT, 0, 32'h20C, 0, 1, 0, 0, 3);
        addV(0, OP_HALT, 0, 32'h210, 0, 0, 0, 0, 4);
        addV(0, OP_HALT, 0, 32'h210, 0, 0, 0, 0, 4);
        addV(0, OP_HALT, 0, 32'h210, 1, 1, 0, 0, 4);  withHead(32'h200);
        addV(0, OP_HALT, 0, 32'h214, 0, 0, 0, 0, 4);  withHead(32'h204);
    endtask

    // ---------------- test ----------------
    initial begin
        drive(0, OP_HALT, 0, 32'h0, 0);
        buildTable();
        repeat (3) @(posedge clk);
        #1;
        // values while reset is held
        chk("rst core_en", {31'b0, coreEnA}, 32'd0);
        chk("rst halted", {31'b0, haltedA}, 32'd0);
        chk("rst bp_hit", {31'b0, bpHitA}, 32'd0);
        chk("rst bp_hit_idx", {30'b0, hitIdxA}, 32'd0);
        chk("rst trc_count", {29'b0, countA}, 32'd0);
        chk("rst trc_valid", {31'b0, validA}, 32'd0);
        chk("rst overflow", {31'b0, ovfA}, 32'd0);
        chk("rst core_en B", {31'b0, coreEnB}, 32'd0);
        reset = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].cv, vecs[k].op, vecs[k].arg, vecs[k].pc, vecs[k].rdy);
            if (vecs[k].bw) begin
                bpWr = 1'b1;  bpIdx = vecs[k].bi;  bpAddr = vecs[k].ba;  bpEn = vecs[k].be;
            end
            #1;
            chk($sformatf("v%0d core_en", k), {31'b0, coreEnA}, {31'b0, vecs[k].eCore});
            chk($sformatf("v%0d halted", k), {31'b0, haltedA}, {31'b0, vecs[k].eHalt});
            chk($sformatf("v%0d bp_hit", k), {31'b0, bpHitA}, {31'b0, vecs[k].eHit});
            chk($sformatf("v%0d trc_count", k), {29'b0, countA}, {29'b0, vecs[k].eCnt});
            if (vecs[k].chkHead) begin
                chk($sformatf("v%0d trc_pc", k), tPcA, vecs[k].eHead);
                chk($sformatf("v%0d trc_inst", k), tInstA, instOf(vecs[k].eHead));
                chk($sformatf("v%0d trc_data", k), tDataA, ~vecs[k].eHead);
            end
            if (vecs[k].chkIdx)
                chk($sformatf("v%0d bp_hit_idx", k), {30'b0, hitIdxA}, {30'b0, vecs[k].eIdx});
            step();
        end

        // overwrite mode: 6 retirements into depth 4 (dut B); dut A stops at 4
        drive(1, OP_HALT, 0, 32'h214, 0);  step();
        drive(1, OP_CLR, 0, 32'h214, 0);   step();
        drive(1, OP_RUN, 0, 32'h300, 0);   step();
        for (int i = 0; i < 6; i++) begin
            drive(i == 5, OP_HALT, 0, 32'h300 + 32'(4 * i), 0);
            #1;
            chk($sformatf("ovw retire %0d", i), {31'b0, coreEnB}, 32'd1);
            step();
        end
        drive(0, OP_HALT, 0, 32'h318, 0);
        #1;
        chk("ovw count B", {29'b0, countB}, 32'd4);
        chk("ovw overflow B", {31'b0, ovfB}, 32'd1);
        chk("ovw head B", tPcB, 32'h308);
        chk("ovw halted B", {31'b0, haltedB}, 32'd1);
        chk("full count A", {29'b0, countA}, 32'd4);
        chk("full overflow A", {31'b0, ovfA}, 32'd0);
        chk("full head A", tPcA, 32'h300);
        step();
        drive(1, OP_CLR, 0, 32'h318, 0);  step();
        drive(0, OP_HALT, 0, 32'h318, 1);
        #1;
        chk("clr count B", {29'b0, countB}, 32'd0);
        chk("clr overflow B", {31'b0, ovfB}, 32'd0);
        chk("clr valid B", {31'b0, validB}, 32'd0);
        step();
        drive(0, OP_HALT, 0, 32'h318, 0);
        #1;
        chk("pop empty count A", {29'b0, countA}, 32'd0);

        // reset asserted mid-RUN with three entries buffered
        drive(1, OP_RUN, 0, 32'h400, 0);  step();
        for (int i = 0; i < 3; i++) begin
            drive(0, OP_HALT, 0, 32'h400 + 32'(4 * i), 0);
            #1;
            chk($sformatf("pre-rst retire %0d", i), {31'b0, coreEnA}, 32'd1);
            step();
        end
        drive(0, OP_HALT, 0, 32'h40C, 0);
        #1;
        chk("pre-rst count", {29'b0, countA}, 32'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("mid-rst core_en", {31'b0, coreEnA}, 32'd0);
        chk("mid-rst count", {29'b0, countA}, 32'd0);
        chk("mid-rst valid", {31'b0, validA}, 32'd0);
        chk("mid-rst halted", {31'b0, haltedA}, 32'd0);
        chk("mid-rst bp_hit_idx", {30'b0, hitIdxA}, 32'd0);
        chk("mid-rst count B", {29'b0, countB}, 32'd0);
        step();
        reset = 1'b1;
        drive(0, OP_HALT, 0, 32'h58, 0);
        #1;
        chk("bp cleared by reset", {31'b0, coreEnA}, 32'd1);
        step();
        // slot written at the current pc does not fire in the write cycle
        drive(0, OP_HALT, 0, 32'h64, 0);
        bpWr = 1'b1;  bpIdx = 2'd1;  bpAddr = 32'h64;  bpEn = 1'b1;
        #1;
        chk("bp write same cycle", {31'b0, coreEnA}, 32'd1);
        step();
        // breakpoint and HALT command together
        drive(1, OP_HALT, 0, 32'h64, 0);
        #1;
        chk("bp new slot stop", {31'b0, coreEnA}, 32'd0);
        step();
        drive(0, OP_HALT, 0, 32'h64, 0);
        #1;
        chk("bp+halt halted", {31'b0, haltedA}, 32'd1);
        chk("bp+halt bp_hit", {31'b0, bpHitA}, 32'd1);
        chk("bp+halt idx", {30'b0, hitIdxA}, 32'd1);
        chk("bp+halt count", {29'b0, countA}, 32'd2);
        step();
        #1;
        chk("bp_hit one pulse", {31'b0, bpHitA}, 32'd0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
